// File: rtl/regfile_pkg.sv
// Shared constants and packed-bus helper for the multi-port register file.
package regfile_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int ZERO_ADDR  = 0;
  localparam int FIELD_MAX  = 64;
  localparam int BUS_MAX    = 256;

  // Field k of width w from a packed bus, zero-extended to FIELD_MAX bits.
  function automatic logic [FIELD_MAX-1:0] port_field(input logic [BUS_MAX-1:0] bus,
                                                      input int k, input int w);
    logic [BUS_MAX-1:0]   shifted;
    logic [FIELD_MAX-1:0] mask;
    shifted = bus >> (k * w);
    mask    = (FIELD_MAX'(1) << w) - FIELD_MAX'(1);
    return shifted[FIELD_MAX-1:0] & mask;
  endfunction
endpackage

// File: rtl/regfile_mp_if.sv
// Issue/write-back side bus of the register file; master drives writes and read addresses.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic                     wr0_en;
  logic [ADDR_W-1:0]        wr0_addr;
  logic [DATA_W-1:0]        wr0_data;
  logic                     wr1_en;
  logic [ADDR_W-1:0]        wr1_addr;
  logic [DATA_W-1:0]        wr1_data;
  logic                     busy_set_en;
  logic [ADDR_W-1:0]        busy_set_addr;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     waw_err;

  modport master (
    output wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
           busy_set_en, busy_set_addr, rd_addr,
    input  rd_data, rd_busy, waw_err
  );
  modport slave (
    input  wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
           busy_set_en, busy_set_addr, rd_addr,
    output rd_data, rd_busy, waw_err
  );
endinterface

// File: rtl/regfile_rd_port.sv
// One read port: wr1 > wr0 > array bypass mux plus pending flag; 0-cycle latency, no backpressure.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic              wr0_en_i,
  input  logic [ADDR_W-1:0] wr0_addr_i,
  input  logic [DATA_W-1:0] wr0_data_i,
  input  logic              wr1_en_i,
  input  logic [ADDR_W-1:0] wr1_addr_i,
  input  logic [DATA_W-1:0] wr1_data_i,
  input  logic [DATA_W-1:0] arr_data_i,
  input  logic              busy_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_busy_o
);
  logic hit0, hit1, is_zero;

  assign hit0    = wr0_en_i && (wr0_addr_i == rd_addr_i);
  assign hit1    = wr1_en_i && (wr1_addr_i == rd_addr_i);
  assign is_zero = (ZERO_REG != 0) && (rd_addr_i == ADDR_W'(ZERO_ADDR));

  always_comb begin
    rd_data_o = arr_data_i;
    rd_busy_o = busy_i & ~hit1;
    if (hit1)      rd_data_o = wr1_data_i;
    else if (hit0) rd_data_o = wr0_data_i;
    // Bypass would otherwise leak write-port data while reset is held.
    if (!rst_n || is_zero) begin
      rd_data_o = '0;
      rd_busy_o = 1'b0;
    end
  end
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with two write ports, same-cycle bypass and busy scoreboard.
// Reads are combinational; writes and busy updates land on the clk rising edge; never stalls.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_mp_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0]        mem_q [DEPTH];
  logic [DEPTH-1:0]         busy_q, busy_d;
  logic                     waw_err_q, waw_err_d;
  logic                     wr0_ok, wr1_ok, set_ok;
  logic [NUM_RD*DATA_W-1:0] rd_data_w;
  logic [NUM_RD-1:0]        rd_busy_w;

  assign wr0_ok = bus.wr0_en && !((ZERO_REG != 0) && (bus.wr0_addr == ADDR_W'(ZERO_ADDR)));
  assign wr1_ok = bus.wr1_en && !((ZERO_REG != 0) && (bus.wr1_addr == ADDR_W'(ZERO_ADDR)));
  assign set_ok = bus.busy_set_en &&
                  !((ZERO_REG != 0) && (bus.busy_set_addr == ADDR_W'(ZERO_ADDR)));

  always_comb begin
    busy_d = busy_q;
    if (bus.wr1_en) busy_d[bus.wr1_addr] = 1'b0;
    // A new issue overrides a retirement to the same register.
    if (set_ok) busy_d[bus.busy_set_addr] = 1'b1;
    waw_err_d = waw_err_q;
    if (bus.wr0_en && busy_q[bus.wr0_addr] &&
        !(bus.wr1_en && (bus.wr1_addr == bus.wr0_addr)))
      waw_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      busy_q    <= '0;
      waw_err_q <= 1'b0;
    end else begin
      if (wr0_ok) mem_q[bus.wr0_addr] <= bus.wr0_data;
      if (wr1_ok) mem_q[bus.wr1_addr] <= bus.wr1_data;
      busy_q    <= busy_d;
      waw_err_q <= waw_err_d;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr_k;
    assign addr_k = ADDR_W'(port_field(BUS_MAX'(bus.rd_addr), k, ADDR_W));

    regfile_rd_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_rd_port (
      .rst_n      (rst_n),
      .rd_addr_i  (addr_k),
      .wr0_en_i   (bus.wr0_en),
      .wr0_addr_i (bus.wr0_addr),
      .wr0_data_i (bus.wr0_data),
      .wr1_en_i   (bus.wr1_en),
      .wr1_addr_i (bus.wr1_addr),
      .wr1_data_i (bus.wr1_data),
      .arr_data_i (mem_q[addr_k]),
      .busy_i     (busy_q[addr_k]),
      .rd_data_o  (rd_data_w[k*DATA_W +: DATA_W]),
      .rd_busy_o  (rd_busy_w[k])
    );
  end

  assign bus.rd_data = rd_data_w;
  assign bus.rd_busy = rd_busy_w;
  assign bus.waw_err = waw_err_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp built with four read ports.
module tb_regfile_mp;
  import regfile_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4)) bus ();

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .ZERO_REG(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rdd(input logic [127:0] d, input int k);
    return 32'(port_field(BUS_MAX'(d), k, 32));
  endfunction

  task automatic set_rd(input logic [4:0] a0, a1, a2, a3);
    bus.rd_addr = {a3, a2, a1, a0};
  endtask

  task automatic idle_inputs();
    bus.wr0_en = 1'b0; bus.wr0_addr = '0; bus.wr0_data = '0;
    bus.wr1_en = 1'b0; bus.wr1_addr = '0; bus.wr1_data = '0;
    bus.busy_set_en = 1'b0; bus.busy_set_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    set_rd(5'd0, 5'd5, 5'd31, 5'd0);
    bus.wr0_en = 1'b1; bus.wr0_addr = 5'd5; bus.wr0_data = 32'hFFFF_0000;
    #12;
    n_checks++;
    if (rdd(bus.rd_data, 1) !== 32'h0) begin
      n_fail++; $display("FAIL reset_held_bypass: got %h want 0", rdd(bus.rd_data, 1));
    end
    bus.wr0_en = 1'b0;
    tick();
    rst_n = 1'b1;
    #2;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (rdd(bus.rd_data, k) !== 32'h0) begin
        n_fail++; $display("FAIL reset_data_p%0d: got %h want 0", k, rdd(bus.rd_data, k));
      end
      n_checks++;
      if (bus.rd_busy[k] !== 1'b0) begin
        n_fail++; $display("FAIL reset_busy_p%0d: got %b want 0", k, bus.rd_busy[k]);
      end
    end
    n_checks++;
    if (bus.waw_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_waw: got %b want 0", bus.waw_err);
    end
  endtask

  task automatic test_write_bypass();
    tick();
    set_rd(5'd5, 5'd0, 5'd0, 5'd0);
    bus.wr0_en = 1'b1; bus.wr0_addr = 5'd5; bus.wr0_data = 32'hDEAD_BEEF;
    #2;
    n_checks++;
    if (rdd(bus.rd_data, 0) !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL bypass_wr0: got %h want deadbeef", rdd(bus.rd_data, 0));
    end
    tick();
    bus.wr0_en = 1'b0;
    #2;
    n_checks++;
    if (rdd(bus.rd_data, 0) !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL array_wr0: got %h want deadbeef", rdd(bus.rd_data, 0));
    end
  endtask

  task automatic test_zero_reg();
    tick();
    set_rd(5'd0, 5'd0, 5'd0, 5'd0);
    bus.wr0_en = 1'b1; bus.wr0_addr = 5'd0; bus.wr0_data = 32'h1234_5678;
    bus.wr1_en = 1'b1; bus.wr1_addr = 5'd0; bus.wr1_data = 32'h1234_5678;
    bus.busy_set_en = 1'b1; bus.busy_set_addr = 5'd0;
    #2;
    n_checks++;
    if (rdd(bus.rd_data, 0) !== 32'h0) begin
      n_fail++; $display("FAIL zero_bypass: got %h want 0", rdd(bus.rd_data, 0));
    end
    tick();
    idle_inputs();
    #2;
    n_checks++;
    if (rdd(bus.rd_data, 0) !== 32'h0) begin
      n_fail++; $display("FAIL zero_array: got %h want 0", rdd(bus.rd_data, 0));
    end
    n_checks++;
    if (bus.rd_busy[0] !== 1'b0) begin
      n_fail++; $display("FAIL zero_busy: got %b want 0", bus.rd_busy[0]);
    end
  endtask

  task automatic test_scoreboard();
    tick();
    set_rd(5'd10, 5'd0, 5'd0, 5'd0);
    bus.busy_set_en = 1'b1; bus.busy_set_addr = 5'd10;
    #2;
    n_checks++;
    if (bus.rd_busy[0] !== 1'b0) begin
      n_fail++; $display("FAIL busy_set_same_cycle: got %b want 0", bus.rd_busy[0]);
    end
    tick();
    bus.busy_set_en = 1'b0;
    #2;
    n_checks++;
    if (bus.rd_busy[0] !== 1'b1) begin
      n_fail++; $display("FAIL busy_set_next: got %b want 1", bus.rd_busy[0]);
    end
    bus.wr1_en = 1'b1; bus.wr1_addr = 5'd10; bus.wr1_data = 32'hCAFE_CAFE;
    #1;
    n_checks++;
    if (bus.rd_busy[0] !== 1'b0) begin
      n_fail++; $display("FAIL busy_clear_bypass: got %b want 0", bus.rd_busy[0]);
    end
    n_checks++;
    if (rdd(bus.rd_data, 0) !== 32'hCAFE_CAFE) begin
      n_fail++; $display("FAIL wr1_bypass: got %h want cafecafe", rdd(bus.rd_data, 0));
    end
    tick();
    bus.wr1_en = 1'b0;
    #2;
    n_checks++;
    if (bus.rd_busy[0] !== 1'b0) begin
      n_fail++; $display("FAIL busy_cleared: got %b want 0", bus.rd_busy[0]);
    end
    bus.wr1_en = 1'b1;
    bus.busy_set_en = 1'b1; bus.busy_set_addr = 5'd10;
    tick();
    idle_inputs();
    #2;
    n_checks++;
    if (bus.rd_busy[0] !== 1'b1) begin
      n_fail++; $display("FAIL set_over_clear: got %b want 1", bus.rd_busy[0]);
    end
    bus.wr1_en = 1'b1; bus.wr1_addr = 5'd10; bus.wr1_data = 32'hCAFE_CAFE;
    tick();
    idle_inputs();
  endtask

  task automatic test_priority_waw();
    set_rd(5'd7, 5'd8, 5'd9, 5'd0);
    bus.wr0_en = 1'b1; bus.wr0_addr = 5'd7; bus.wr0_data = 32'h1111;
    bus.wr1_en = 1'b1; bus.wr1_addr = 5'd7; bus.wr1_data = 32'h2222;
    bus.busy_set_en = 1'b1; bus.busy_set_addr = 5'd8;
    tick();
    idle_inputs();
    #2;
    n_checks++;
    if (rdd(bus.rd_data, 0) !== 32'h2222) begin
      n_fail++; $display("FAIL wr1_priority: got %h want 2222", rdd(bus.rd_data, 0));
    end
    bus.wr0_en = 1'b1; bus.wr0_addr = 5'd8; bus.wr0_data = 32'h3333;
    bus.wr1_en = 1'b1; bus.wr1_addr = 5'd8; bus.wr1_data = 32'h4444;
    bus.busy_set_en = 1'b1; bus.busy_set_addr = 5'd9;
    tick();
    idle_inputs();
    #2;
    n_checks++;
    if (bus.waw_err !== 1'b0) begin
      n_fail++; $display("FAIL waw_masked_by_wr1: got %b want 0", bus.waw_err);
    end
    n_checks++;
    if (rdd(bus.rd_data, 1) !== 32'h4444) begin
      n_fail++; $display("FAIL reg8_value: got %h want 4444", rdd(bus.rd_data, 1));
    end
    bus.wr0_en = 1'b1; bus.wr0_addr = 5'd9; bus.wr0_data = 32'hABCD;
    tick();
    idle_inputs();
    #2;
    n_checks++;
    if (bus.waw_err !== 1'b1) begin
      n_fail++; $display("FAIL waw_set: got %b want 1", bus.waw_err);
    end
    n_checks++;
    if (rdd(bus.rd_data, 2) !== 32'hABCD) begin
      n_fail++; $display("FAIL waw_data_written: got %h want abcd", rdd(bus.rd_data, 2));
    end
    n_checks++;
    if (bus.rd_busy[2] !== 1'b1) begin
      n_fail++; $display("FAIL reg9_still_busy: got %b want 1", bus.rd_busy[2]);
    end
    repeat (3) tick();
    n_checks++;
    if (bus.waw_err !== 1'b1) begin
      n_fail++; $display("FAIL waw_sticky: got %b want 1", bus.waw_err);
    end
  endtask

  task automatic test_four_ports();
    set_rd(5'd5, 5'd10, 5'd7, 5'd0);
    #2;
    n_checks++;
    if (rdd(bus.rd_data, 0) !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL four_p0: got %h want deadbeef", rdd(bus.rd_data, 0));
    end
    n_checks++;
    if (rdd(bus.rd_data, 1) !== 32'hCAFE_CAFE) begin
      n_fail++; $display("FAIL four_p1: got %h want cafecafe", rdd(bus.rd_data, 1));
    end
    n_checks++;
    if (rdd(bus.rd_data, 2) !== 32'h2222) begin
      n_fail++; $display("FAIL four_p2: got %h want 2222", rdd(bus.rd_data, 2));
    end
    n_checks++;
    if (rdd(bus.rd_data, 3) !== 32'h0) begin
      n_fail++; $display("FAIL four_p3: got %h want 0", rdd(bus.rd_data, 3));
    end
    n_checks++;
    if (bus.rd_busy !== 4'b0000) begin
      n_fail++; $display("FAIL four_busy: got %b want 0000", bus.rd_busy);
    end
  endtask

  task automatic test_reset_mid();
    set_rd(5'd5, 5'd9, 5'd10, 5'd0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.waw_err !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_waw: got %b want 0", bus.waw_err);
    end
    n_checks++;
    if (rdd(bus.rd_data, 0) !== 32'h0) begin
      n_fail++; $display("FAIL mid_reset_data: got %h want 0", rdd(bus.rd_data, 0));
    end
    n_checks++;
    if (bus.rd_busy[1] !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_busy: got %b want 0", bus.rd_busy[1]);
    end
    tick();
    rst_n = 1'b1;
    bus.wr1_en = 1'b1; bus.wr1_addr = 5'd9; bus.wr1_data = 32'h5555;
    tick();
    idle_inputs();
    #2;
    n_checks++;
    if (rdd(bus.rd_data, 1) !== 32'h5555) begin
      n_fail++; $display("FAIL post_reset_wr1: got %h want 5555", rdd(bus.rd_data, 1));
    end
    n_checks++;
    if (bus.waw_err !== 1'b0 || bus.rd_busy[1] !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_flags: waw %b busy %b want 0 0", bus.waw_err, bus.rd_busy[1]);
    end
    n_checks++;
    if (rdd(bus.rd_data, 0) !== 32'h0) begin
      n_fail++; $display("FAIL post_reset_reg5: got %h want 0", rdd(bus.rd_data, 0));
    end
  endtask

  initial begin
    test_reset();
    test_write_bypass();
    test_zero_reg();
    test_scoreboard();
    test_priority_waw();
    test_four_ports();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
